// File: rtl/adc_result_bank_if.sv
// Frame-in / sample-out bus of the ADC result bank.
//   frame, frame_valid : captured 16-bit DOUT frame and its one-cycle strobe
//   out_data           : FIFO head, {addr[2:0], data[DIGITS-1:0]}
//   out_valid          : FIFO holds at least one sample
//   out_ready          : consumer accepts the head this cycle
// master = system side (drives frames, consumes samples); slave = the bank.
interface adc_result_bank_if #(
    parameter int DIGITS = 8
);
    logic [15:0]       frame;
    logic              frame_valid;
    logic [DIGITS+2:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output frame, frame_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  frame, frame_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/adc_result_bank.sv
// Validates captured AD79X8 DOUT frames, keeps the latest result per channel
// with a fresh flag, tracks completion of a programmed channel sequence and
// forwards tagged samples through a ready/valid FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : frame/frame_valid in, out_data/out_valid/out_ready stream
//   seq_mask     : channels forming one sequence
//   clear_stats  : clears frame_err, overflow and the sequence tracker
//   rd_ch/rd_ack : bank read select / clear fresh flag of rd_ch
//   rd_data/rd_fresh : bank[rd_ch], fresh[rd_ch] (combinational)
//   fifo_level   : FIFO occupancy 0..FIFO_DEPTH
//   seq_done     : one-cycle pulse when every channel of seq_mask was seen
//   frame_err    : sticky malformed-frame flag
//   overflow     : sticky sample-dropped flag
module adc_result_bank #(
    parameter int DIGITS     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    adc_result_bank_if.slave              bus,
    input  logic [7:0]                    seq_mask,
    input  logic                          clear_stats,
    input  logic [2:0]                    rd_ch,
    input  logic                          rd_ack,
    output logic [DIGITS-1:0]             rd_data,
    output logic                          rd_fresh,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          seq_done,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = DIGITS + 3;
    // Trailing pad bits below the result that must read as zero.
    localparam logic [11:0] PAD_MASK = 12'((1 << (12 - DIGITS)) - 1);

    logic [DIGITS-1:0] bank [8];
    logic [7:0]        fresh;
    logic [7:0]        seen;
    logic [WW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic [2:0]        addr;
    logic [DIGITS-1:0] data;
    logic [WW-1:0]     push_word;
    logic              frame_ok;
    logic              good;
    logic              bad;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [7:0]        nxt_seen;
    logic              seq_hit;

    always_comb begin
        addr      = bus.frame[14:12];
        data      = bus.frame[11 -: DIGITS];
        push_word = {addr, data};
        frame_ok  = !bus.frame[15] && ((bus.frame[11:0] & PAD_MASK) == '0);
        good      = bus.frame_valid && frame_ok;
        bad       = bus.frame_valid && !frame_ok;
        full      = (fifo_level == LW'(FIFO_DEPTH));
        empty     = (fifo_level == '0);
        pop       = !empty && bus.out_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = good && (!full || pop);
        drop      = good && full && !pop;
        nxt_seen  = seen | (8'b1 << addr);
        seq_hit   = (seq_mask != '0) && ((nxt_seen & seq_mask) == seq_mask);
    end

    assign rd_data       = bank[rd_ch];
    assign rd_fresh      = fresh[rd_ch];
    assign bus.out_valid = !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                bank[i] <= '0;
            end
            fresh        <= '0;
            seen         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            bus.out_data <= '0;
            seq_done     <= 1'b0;
            frame_err    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // Bank: write is ordered after the ack so a same-channel write wins.
            if (rd_ack) begin
                fresh[rd_ch] <= 1'b0;
            end
            if (good) begin
                bank[addr]  <= data;
                fresh[addr] <= 1'b1;
            end

            // FIFO storage and pointers.
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);

            // out_data is a registered copy of the next head; it holds when
            // the FIFO drains so the last sample stays visible.
            if (pop) begin
                if (fifo_level > LW'(1)) begin
                    bus.out_data <= mem[rd_ptr + PW'(1)];
                end else if (push) begin
                    bus.out_data <= push_word;
                end
            end else if (empty && push) begin
                bus.out_data <= push_word;
            end

            // Sequence tracker; a frame coinciding with clear_stats is not counted.
            seq_done <= good && !clear_stats && seq_hit;
            if (clear_stats) begin
                seen <= '0;
            end else if (good) begin
                seen <= seq_hit ? '0 : (nxt_seen & seq_mask);
            end

            // Sticky flags; clear takes priority over a same-cycle set.
            if (clear_stats) begin
                frame_err <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (bad)  frame_err <= 1'b1;
                if (drop) overflow  <= 1'b1;
            end
        end
    end
endmodule
